matrix_slot_writer: RTL
=======================

Name: matrix_slot_writer

Overview:
- Responder side of the compute/input subsystem matrix write interface (write_request / write_ready / write_data_valid / writer_ready / write_done).
- Accepts one matrix per transaction and stores it into the shared matrix BRAM slot for its ID.
- Slot layout: a 3-word header (descriptor plus 8-byte name) followed by row-major data.
- Commits the valid bit last, so matrix scanners never see a partially written matrix.

Parameters:
- BLOCK_SIZE, 1152, words per matrix slot; slot base address = id*BLOCK_SIZE.
- DATA_WIDTH, 32, BRAM and data word width.
- ADDR_WIDTH, 14, BRAM address width.
- HDR_WORDS, 3, header words per slot; data starts at base+HDR_WORDS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- write_request  in  1  initiator requests a matrix write; held until accepted.
- write_ready  out  1  high in IDLE; request accepted on a cycle with write_request&&write_ready.
- write_matrix_id  in  3  target slot ID, sampled at acceptance.
- write_rows  in  8  row count, sampled at acceptance.
- write_cols  in  8  column count, sampled at acceptance.
- write_name  in  8x8  name bytes [0:7], sampled at acceptance.
- write_data  in  DATA_WIDTH  element value, row-major.
- write_data_valid  in  1  data beat strobe.
- writer_ready  out  1  high while in DATA; a beat transfers when write_data_valid&&writer_ready.
- write_done  out  1  one-cycle pulse after the final header commit.
- write_error  out  1  one-cycle pulse when a request is rejected.
- bram_wr_en  out  1  BRAM write enable.
- bram_wr_addr  out  ADDR_WIDTH  BRAM write address.
- bram_wr_data  out  DATA_WIDTH  BRAM write data.

Behaviour:
- Reset: state=IDLE; write_ready=1; writer_ready=0; write_done=0; write_error=0; bram_wr_en=0; bram_wr_addr=0; bram_wr_data=0; element counter=0.
- All outputs are registered.
- Header word 0 = {id[7:0], rows, cols, 7'b0, valid}.
- Word 1 = {name[0],name[1],name[2],name[3]}; word 2 = {name[4..7]}. name[0] is in bits [31:24].
- Total element count = rows*cols, computed 16-bit unsigned.
- States: IDLE, CHECK, INVAL, DATA, NAME0, NAME1, COMMIT, DONE, ERR.
- IDLE:
  - On acceptance, latch id/rows/cols/name, drop write_ready next cycle, go CHECK.
- CHECK (1 cycle):
  - rows==0, cols==0, or rows*cols > BLOCK_SIZE-HDR_WORDS -> ERR.
  - Otherwise -> INVAL.
- ERR: write_error=1 for exactly one cycle, no BRAM write, then IDLE.
- INVAL:
  - One write: addr=base, data=0, which clears the old valid bit.
  - Next state DATA; writer_ready rises in the same cycle as that write.
- DATA:
  - Each accepted beat k (0-based) produces a BRAM write on the next cycle: addr=base+HDR_WORDS+k, data=write_data.
  - Gaps in write_data_valid are allowed; bram_wr_en=0 for idle cycles.
  - On acceptance of beat total-1, writer_ready drops on the next cycle; go NAME0.
  - Beats offered while writer_ready=0 are ignored.
- NAME0 writes word 1; NAME1 writes word 2.
- COMMIT writes word 0 with valid=1.
- DONE: write_done=1 for one cycle, bram_wr_en=0, write_ready=1 again next cycle -> IDLE.
- Latency: acceptance to first BRAM write (invalidate) = 2 cycles. Last data write to write_done = 4 cycles.
- write_request while busy is not accepted; the initiator keeps it asserted.
- A new request may be accepted on the cycle after write_done.
- Overflow guard: id*BLOCK_SIZE+HDR_WORDS+total-1 must be < 2**ADDR_WIDTH. Any id violating this -> ERR. With defaults, all ids 0..7 are legal (max base 8064).
- Reset mid-operation: return to IDLE next cycle and de-assert all strobes. An interrupted slot stays invalid because the header was cleared first.
- write_done and write_error are never asserted together.

Test Plan:
- id=1, rows=2, cols=2, name "MAT_A   ", data 10,20,30,40 back-to-back ->
  - writes in order: 1152<=0; 1155..1158<=10,20,30,40; 1153<=0x4D41545F; 1154<=0x41202020; 1152<=0x01020201.
  - Then one write_done pulse.
- Same transfer with write_data_valid high every third cycle -> identical BRAM contents and write order. writer_ready stays high until the 4th beat.
- rows=0, cols=5 -> write_error pulse, zero bram_wr_en cycles, write_ready back high 2 cycles later. Also rows=40, cols=40 (1600>1149) -> write_error.
- id=7, rows=1, cols=1, data 0xDEADBEEF -> 8067<=0xDEADBEEF, header 8064<=0x07010101.
- Second write_request held during DATA -> not accepted until the cycle after write_done. Then the second matrix is written correctly.
- rst pulse after 2 of 4 beats -> outputs return to reset values next cycle. Slot header reads 0 (invalid). A following full request completes normally.

Source files
------------

// File: rtl/matrix_slot_writer.sv
// rtl/matrix_slot_writer.sv - responder that stores one matrix per transaction into its BRAM slot
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   write_request/ready   request handshake; id/rows/cols/name sampled on acceptance
//   write_matrix_id       target slot (base address = id*BLOCK_SIZE)
//   write_rows/cols       matrix shape; element count = rows*cols
//   write_name[0:7]       8-byte name stored in header words 1 and 2
//   write_data/valid      row-major element beats, transfer on valid && writer_ready
//   writer_ready          high while beats are being accepted
//   write_done            one-cycle pulse after the header commit
//   write_error           one-cycle pulse when a request is rejected
//   bram_wr_en/addr/data  BRAM write port
//
// Slot layout: word0 = {id, rows, cols, 7'b0, valid}, word1/word2 = name bytes,
// words HDR_WORDS.. = data. Word0 is cleared first and rewritten with valid=1
// last, so a scanner never sees a half-written matrix as valid.

module matrix_slot_writer #(
  parameter int BLOCK_SIZE = 1152,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int HDR_WORDS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_request,
  output logic                  write_ready,
  input  logic [2:0]            write_matrix_id,
  input  logic [7:0]            write_rows,
  input  logic [7:0]            write_cols,
  input  logic [7:0]            write_name [0:7],
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_data_valid,
  output logic                  writer_ready,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data
);

  localparam logic [63:0] ADDR_SPAN  = 64'd1 << ADDR_WIDTH;
  localparam logic [63:0] MAX_ELEMS  = 64'(BLOCK_SIZE - HDR_WORDS);
  localparam logic [63:0] BLOCK_SZ64 = 64'(BLOCK_SIZE);
  localparam logic [63:0] HDR64      = 64'(HDR_WORDS);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_INVAL, S_DATA, S_NAME0, S_NAME1, S_COMMIT, S_DONE, S_ERR
  } state_t;

  state_t                state;
  logic [2:0]            id_q;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [7:0]            name_q [0:7];
  logic [15:0]           total_q;
  logic [15:0]           elem_cnt;
  logic [ADDR_WIDTH-1:0] base_q;

  logic [15:0]           total_c;
  logic [63:0]           base_c;
  logic [63:0]           last_c;
  logic                  req_bad;
  logic [ADDR_WIDTH-1:0] data_addr_c;
  logic                  beat_accept;

  // Validation runs on the latched request during CHECK. Address arithmetic
  // is done wide so the overflow guard itself cannot wrap.
  always_comb begin
    total_c     = {8'd0, rows_q} * {8'd0, cols_q};
    base_c      = 64'(id_q) * BLOCK_SZ64;
    last_c      = base_c + HDR64 + 64'(total_c) - 64'd1;
    req_bad     = (rows_q == 8'd0) || (cols_q == 8'd0) ||
                  (64'(total_c) > MAX_ELEMS) || (last_c >= ADDR_SPAN);
    data_addr_c = base_q + ADDR_WIDTH'(HDR_WORDS) + ADDR_WIDTH'(elem_cnt);
    beat_accept = write_data_valid && writer_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      write_ready  <= 1'b1;
      writer_ready <= 1'b0;
      write_done   <= 1'b0;
      write_error  <= 1'b0;
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= '0;
      bram_wr_data <= '0;
      elem_cnt     <= '0;
      total_q      <= '0;
      base_q       <= '0;
      id_q         <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      for (int i = 0; i < 8; i++) name_q[i] <= '0;
    end else begin
      bram_wr_en  <= 1'b0;
      write_done  <= 1'b0;
      write_error <= 1'b0;

      case (state)
        S_IDLE: begin
          // Ready re-rises one cycle after DONE/ERR hands control back here.
          write_ready <= 1'b1;
          if (write_request && write_ready) begin
            id_q        <= write_matrix_id;
            rows_q      <= write_rows;
            cols_q      <= write_cols;
            for (int i = 0; i < 8; i++) name_q[i] <= write_name[i];
            write_ready <= 1'b0;
            state       <= S_CHECK;
          end
        end

        S_CHECK: begin
          elem_cnt <= '0;
          total_q  <= total_c;
          base_q   <= ADDR_WIDTH'(base_c);
          if (req_bad) begin
            write_error <= 1'b1;
            state       <= S_ERR;
          end else begin
            // Invalidate the header first; beats may already transfer
            // in the same cycle this write is presented.
            bram_wr_en   <= 1'b1;
            bram_wr_addr <= ADDR_WIDTH'(base_c);
            bram_wr_data <= '0;
            writer_ready <= 1'b1;
            state        <= S_INVAL;
          end
        end

        S_INVAL, S_DATA: begin
          if (state == S_INVAL) state <= S_DATA;
          if (beat_accept) begin
            bram_wr_en   <= 1'b1;
            bram_wr_addr <= data_addr_c;
            bram_wr_data <= write_data;
            elem_cnt     <= elem_cnt + 16'd1;
            if (elem_cnt == total_q - 16'd1) begin
              writer_ready <= 1'b0;
              state        <= S_NAME0;
            end
          end
        end

        S_NAME0: begin
          bram_wr_en   <= 1'b1;
          bram_wr_addr <= base_q + ADDR_WIDTH'(1);
          bram_wr_data <= DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
          state        <= S_NAME1;
        end

        S_NAME1: begin
          bram_wr_en   <= 1'b1;
          bram_wr_addr <= base_q + ADDR_WIDTH'(2);
          bram_wr_data <= DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
          state        <= S_COMMIT;
        end

        S_COMMIT: begin
          bram_wr_en   <= 1'b1;
          bram_wr_addr <= base_q;
          bram_wr_data <= DATA_WIDTH'({5'd0, id_q, rows_q, cols_q, 7'd0, 1'b1});
          state        <= S_DONE;
        end

        S_DONE: begin
          write_done <= 1'b1;
          state      <= S_IDLE;
        end

        S_ERR: begin
          write_ready <= 1'b1;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
